// File: rtl/sum_block_accumulator_pkg.sv
// Types and constants shared by the block accumulator and the adder-side wrapper.
package sum_block_accumulator_pkg;

  localparam int SUM_W   = 5;
  localparam int SUM_MAX = 30;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  function automatic int worst_case_total(input int count_n);
    return count_n * SUM_MAX;
  endfunction

endpackage

// File: rtl/sum_block_accumulator_if.sv
// Stream-in / block-total-out handshake bundle for the block accumulator.
interface sum_block_accumulator_if #(
  parameter int ACC_W = 8
);
  import sum_block_accumulator_pkg::*;

  logic             clear;
  logic             in_valid;
  logic [SUM_W-1:0] in_sum;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  modport master (
    output clear, in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  clear, in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );

endinterface

// File: rtl/sum_block_counter.sv
// Sample counter for one block; last_o flags that the next accept completes the block.
module sum_block_counter #(
  parameter int COUNT_N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic last_o
);
  localparam int CNT_W = $clog2(COUNT_N + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == CNT_W'(COUNT_N - 1));

endmodule

// File: rtl/sum_block_accumulator.sv
// Sums COUNT_N adder results into an ACC_W total with sticky overflow.
// States: ACCUM adds accepted samples; DONE presents the total until out_ready.
module sum_block_accumulator
  import sum_block_accumulator_pkg::*;
#(
  parameter int ACC_W   = 8,
  parameter int COUNT_N = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  sum_block_accumulator_if.slave  bus
);
  localparam longint ACC_MAX      = (longint'(1) << ACC_W) - 1;
  localparam bit     OVF_POSSIBLE = longint'(worst_case_total(COUNT_N)) > ACC_MAX;

  if (ACC_W < SUM_W) begin : g_bad_acc_w
    $error("sum_block_accumulator: ACC_W must be >= SUM_W");
  end
  if (COUNT_N < 1) begin : g_bad_count_n
    $error("sum_block_accumulator: COUNT_N must be >= 1");
  end

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic [ACC_W:0]   sum_d;
  logic             carry_d;
  logic             accept;
  logic             handshake;
  logic             last;

  always_comb begin
    sum_d     = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, bus.in_sum};
    // When the block total cannot exceed ACC_W bits the flag is constant zero.
    carry_d   = OVF_POSSIBLE & sum_d[ACC_W];
    accept    = (state_q == ACCUM) & bus.in_valid & ~bus.clear;
    handshake = (state_q == DONE) & bus.out_ready & ~bus.clear;
  end

  sum_block_counter #(
    .COUNT_N (COUNT_N)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (accept),
    .clr_i  (bus.clear | handshake),
    .last_o (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (bus.clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_q <= sum_d[ACC_W-1:0];
            ovf_q <= ovf_q | carry_d;
            if (last) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (handshake) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ACCUM;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: doc/sum_block_accumulator.md
Name: sum_block_accumulator

Overview:
- Downstream consumer of the 4-bit carry-look-ahead adder's 5-bit result (carry-out concatenated with the 4-bit sum).
- Captures a stream of adder results under a valid/ready handshake.
- Accumulates COUNT_N results into a wider running total, then presents the block total with a sticky overflow flag to the next stage.
- Holds the total until the next stage accepts it.

Parameters:
- SUM_W, 5, width of each incoming adder result (4 sum bits plus carry-out); fixed, not overridden.
- ACC_W, 8, accumulator width; must be >= SUM_W.
- COUNT_N, 8, adder results per block; must be >= 1.
- CNT_W, $clog2(COUNT_N+1), sample counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort of current block; 1-cycle pulse.
- in_valid  input  1  in_sum is valid this cycle.
- in_sum  input  SUM_W  adder result, unsigned 0..30.
- in_ready  output  1  block can accept in_sum this cycle.
- out_valid  output  1  out_acc/out_ovf hold a completed block total.
- out_ready  input  1  downstream accepts the total.
- out_acc  output  ACC_W  block total modulo 2^ACC_W.
- out_ovf  output  1  sticky: some addition in this block carried out of ACC_W.

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-high.
- Reset values (asserted asynchronously, held while rst=1):
  - State = ACCUM.
  - acc = 0, cnt = 0, ovf = 0.
  - out_valid = 0, in_ready = 1, out_acc = 0, out_ovf = 0.
- States: ACCUM, DONE. Two-state FSM, registered state.
- ACCUM:
  - in_ready = 1, out_valid = 0.
  - Accept when in_valid=1: acc <= acc + zero-extended in_sum; cnt <= cnt+1.
  - If the ACC_W-bit addition carries out, ovf <= 1. acc wraps modulo 2^ACC_W.
  - If the accept occurs with cnt == COUNT_N-1, go to DONE next cycle. The final sample is included in acc.
  - No accept (in_valid=0): all state held.
- DONE:
  - in_ready = 0, out_valid = 1.
  - out_acc = acc and out_ovf = ovf, both stable while out_ready = 0.
  - in_valid is ignored; no input is consumed in DONE.
  - Handshake completes when out_valid && out_ready. Next cycle: state = ACCUM, acc = 0, cnt = 0, ovf = 0.
- Latency: out_valid rises on the cycle after the COUNT_N-th accept. Minimum block period is COUNT_N+1 cycles (COUNT_N accepts plus 1 DONE cycle with out_ready=1).
- out_acc and out_ovf:
  - Driven directly from acc and ovf registers; no combinational path from in_sum.
  - In ACCUM they show the running partial total; downstream treats them as valid only when out_valid=1.
- clear:
  - Priority below rst, above all other events.
  - Next cycle: state = ACCUM, acc = cnt = ovf = 0, out_valid = 0.
  - A sample offered in the same cycle as clear is discarded; in_ready stays 1 in ACCUM, but the data is not added.
  - A pending total in DONE is dropped without a handshake.
- COUNT_N = 1: every accept goes straight to DONE.
- in_valid must not be gated on in_ready. Upstream holds in_sum stable until accepted.
- Reset mid-block: partial total is lost; the block restarts from zero after rst deasserts.

Decomposition:
- Shared package holds:
  - the state enum (ACCUM, DONE);
  - SUM_W = 5 constant, also used by the adder-side wrapper;
  - a function computing the worst-case total, COUNT_N*30, for elaboration-time checks (warning when it exceeds 2^ACC_W-1).
- One natural sub-module: sum_block_counter.
  - Holds the CNT_W sample counter with inc, clr and last (cnt == COUNT_N-1) outputs.
  - FSM, accumulator and overflow logic stay in the top.

Test Plan:
- rst pulsed for 2 cycles while in DONE, partway through the clk period → immediately out_valid=0, in_ready=1, out_acc=0, out_ovf=0. The next 8 samples of 5'd1 give out_acc=8.
- Defaults, 8 back-to-back samples of 5'd10 with out_ready=1 → out_valid high for exactly 1 cycle, the cycle after the 8th accept; out_acc=80, out_ovf=0; in_ready low on that cycle only.
- in_valid toggling with gaps, samples 0,1,…,7 → out_acc=28 after the 8th accept; no accept counted in gap cycles.
- Backpressure: block completes with out_ready=0 for 5 cycles while in_valid=1 with 5'd30 → out_acc held at its value, in_ready=0, no sample consumed. Then out_ready=1 → ACCUM with acc=0, and the pending 5'd30 is accepted as the first sample of the next block.
- ACC_W=7, 8 samples of 5'd30 → out_acc = 240 mod 128 = 112, out_ovf=1. The next block of 8 × 5'd1 gives out_acc=8, out_ovf=0.
- clear after 3 samples of 5'd5, with a 4th sample offered in the same cycle → that sample is discarded; 8 further samples of 5'd2 give out_acc=16.
